// File: rtl/fft_stage_scheduler.sv
// fft_stage_scheduler: issues radix-2 DIT butterflies stage by stage (addresses, twiddle, precision) and delays them to matching write-backs
module fft_stage_scheduler #(
  parameter int N_LOG2 = 4,
  parameter int BF_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*N_LOG2-1:0]   prec_cfg,
  input  logic                  bf_ready,
  output logic                  busy,
  output logic                  done,
  output logic [N_LOG2-1:0]     stage,
  output logic                  rd_en,
  output logic [N_LOG2-1:0]     rd_addr_a,
  output logic [N_LOG2-1:0]     rd_addr_b,
  output logic [N_LOG2-2:0]     tw_idx,
  output logic                  mult_prec,
  output logic                  add_prec,
  output logic                  wr_en,
  output logic [N_LOG2-1:0]     wr_addr_a,
  output logic [N_LOG2-1:0]     wr_addr_b
);
  localparam int CW = $clog2(BF_LATENCY + 1);
  localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N_LOG2 - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;
  logic [N_LOG2-2:0] k, mask, pos, tw;
  logic [N_LOG2-1:0] half, addr_a;
  logic [1:0] pp;
  logic [CW-1:0] cnt;
  logic [2*N_LOG2-1:0] cfg_q;
  logic [2*N_LOG2:0] dly [BF_LATENCY];
  always_comb begin
    mask = {(N_LOG2-1){1'b1}} >> (LAST - stage);
    pos = k & mask;
    tw = pos << (LAST - stage);
    half = N_LOG2'(1) << stage;
    addr_a = {k & ~mask, 1'b0} | {1'b0, pos};
    pp = 2'(cfg_q >> {stage, 1'b0});
  end
  assign {wr_en, wr_addr_a, wr_addr_b} = dly[BF_LATENCY-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      stage <= '0;
      k <= '0;
      cnt <= '0;
      cfg_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rd_en <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx <= '0;
      mult_prec <= 1'b0;
      add_prec <= 1'b0;
      for (int i = 0; i < BF_LATENCY; i++) dly[i] <= '0;
    end else begin
      busy <= state != IDLE;
      done <= state == DONE;
      rd_en <= state == ISSUE && bf_ready;
      rd_addr_a <= addr_a;
      rd_addr_b <= addr_a + half;
      tw_idx <= tw;
      mult_prec <= pp[1];
      add_prec <= pp[0];
      dly[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int i = 1; i < BF_LATENCY; i++) dly[i] <= dly[i-1];
      case (state)
        IDLE: if (start) begin
          cfg_q <= prec_cfg;
          stage <= '0;
          k <= '0;
          state <= ISSUE;
        end
        ISSUE: if (bf_ready) begin
          k <= k + (N_LOG2-1)'(1);
          if (&k) begin
            state <= DRAIN;
            cnt <= CW'(BF_LATENCY);
          end
        end
        DRAIN: if (cnt == CW'(1)) begin
          state <= stage == LAST ? DONE : ISSUE;
          stage <= stage == LAST ? stage : stage + N_LOG2'(1);
          k <= '0;
        end else cnt <= cnt - CW'(1);
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_stage_scheduler.sv
// tb_fft_stage_scheduler: table, directed and randomized checks of fft_stage_scheduler against a schedule model
module tb_fft_stage_scheduler;
  localparam int MAXC = 128;
  typedef struct {bit rd, wr, dn, bz; int a, b, tw, mp, ap, st, wa, wb;} exp_t;
  typedef struct {int s, k, a, b, tw, mp, ap;} vec_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, start = 0, bf_ready = 0;
  logic [7:0] prec_cfg = 0;
  logic busy0, done0, rd0, mp0, ap0, wr0;
  logic [3:0] stage0, a0, b0, wa0, wb0;
  logic [2:0] tw0;
  logic busy1, done1, rd1, mp1, ap1, wr1;
  logic [2:0] stage1, a1, b1, wa1, wb1;
  logic [1:0] tw1;
  fft_stage_scheduler #(.N_LOG2(4), .BF_LATENCY(2)) d0 (
    .clk(clk), .rst(rst), .start(start), .prec_cfg(prec_cfg), .bf_ready(bf_ready),
    .busy(busy0), .done(done0), .stage(stage0), .rd_en(rd0), .rd_addr_a(a0), .rd_addr_b(b0),
    .tw_idx(tw0), .mult_prec(mp0), .add_prec(ap0), .wr_en(wr0), .wr_addr_a(wa0), .wr_addr_b(wb0));
  fft_stage_scheduler #(.N_LOG2(3), .BF_LATENCY(1)) d1 (
    .clk(clk), .rst(rst), .start(start), .prec_cfg(prec_cfg[5:0]), .bf_ready(bf_ready),
    .busy(busy1), .done(done1), .stage(stage1), .rd_en(rd1), .rd_addr_a(a1), .rd_addr_b(b1),
    .tw_idx(tw1), .mult_prec(mp1), .add_prec(ap1), .wr_en(wr1), .wr_addr_a(wa1), .wr_addr_b(wb1));
  bit rdy_v[MAXC], st_v[MAXC], rst_v[MAXC];
  logic [7:0] cfg_v[MAXC];
  exp_t ex[MAXC];
  bit act_rd[MAXC];
  int act_a[MAXC], act_b[MAXC], act_tw[MAXC], act_mp[MAXC], act_ap[MAXC];
  int wcnt[16];
  int tests = 0, fails = 0, cur_c = 0;
  int o_rd, o_a, o_b, o_tw, o_mp, o_ap, o_st, o_wr, o_wa, o_wb, o_dn, o_bz;
  vec_t tbl[4];
  int fd;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cur_c, act, exp);
    end
  endtask
  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      rdy_v[c] = 1;
      st_v[c] = 0;
      rst_v[c] = 0;
      cfg_v[c] = 0;
    end
  endtask
  // Schedule model: enumerate butterflies block by block, walk time forward over stalls,
  // then a fixed drain per stage; a reset cancels everything at or after its cycle.
  task automatic build(input int nl, input int lat, input int len);
    int free_at, r, c, dn, half;
    free_at = 0;
    for (int q = 0; q < MAXC; q++) ex[q] = '{default: 0};
    for (int t = 0; t < len; t++) begin
      if (st_v[t] && !rst_v[t] && t >= free_at) begin
        r = len;
        for (int q = len - 1; q > t; q--) if (rst_v[q]) r = q;
        c = t;
        for (int s = 0; s < nl; s++) begin
          half = 1 << s;
          for (int blk = 0; blk < (1 << nl); blk += 2 * half)
            for (int j = 0; j < half; j++) begin
              c++;
              while (c < len && !rdy_v[c]) c++;
              if (c < r && c < len) begin
                ex[c].rd = 1;
                ex[c].a = blk + j;
                ex[c].b = blk + j + half;
                ex[c].tw = j * ((1 << nl) / (2 * half));
                ex[c].st = s;
                ex[c].mp = (cfg_v[t] >> (2 * s + 1)) & 1;
                ex[c].ap = (cfg_v[t] >> (2 * s)) & 1;
              end
              if (c + lat < r && c + lat < len) begin
                ex[c+lat].wr = 1;
                ex[c+lat].wa = blk + j;
                ex[c+lat].wb = blk + j + half;
              end
            end
          c += lat;
        end
        dn = c + 1;
        if (dn < r && dn < len) ex[dn].dn = 1;
        for (int q = t + 1; q <= dn && q < r && q < len; q++) ex[q].bz = 1;
        free_at = (r <= dn) ? r + 1 : dn + 1;
      end
    end
  endtask
  task automatic grab(input int sel);
    if (sel == 0) begin
      o_rd = int'(rd0); o_a = int'(a0); o_b = int'(b0); o_tw = int'(tw0); o_mp = int'(mp0); o_ap = int'(ap0);
      o_st = int'(stage0); o_wr = int'(wr0); o_wa = int'(wa0); o_wb = int'(wb0); o_dn = int'(done0); o_bz = int'(busy0);
    end else begin
      o_rd = int'(rd1); o_a = int'(a1); o_b = int'(b1); o_tw = int'(tw1); o_mp = int'(mp1); o_ap = int'(ap1);
      o_st = int'(stage1); o_wr = int'(wr1); o_wa = int'(wa1); o_wb = int'(wb1); o_dn = int'(done1); o_bz = int'(busy1);
    end
  endtask
  task automatic run_scn(input int sel, input int nl, input int lat, input int len, output int first_done);
    build(nl, lat, len);
    first_done = -1;
    for (int i = 0; i < 16; i++) wcnt[i] = 0;
    rst = 1;
    start = 1;
    bf_ready = 1;
    @(posedge clk);
    #1;
    cur_c = -1;
    grab(sel);
    chk("rst_busy", o_bz, 0);
    chk("rst_done", o_dn, 0);
    chk("rst_rd_en", o_rd, 0);
    chk("rst_wr_en", o_wr, 0);
    chk("rst_stage", o_st, 0);
    for (int c = 0; c < len; c++) begin
      rst = rst_v[c];
      start = st_v[c];
      bf_ready = rdy_v[c];
      prec_cfg = cfg_v[c];
      @(posedge clk);
      #1;
      cur_c = c;
      grab(sel);
      chk("busy", o_bz, int'(ex[c].bz));
      chk("done", o_dn, int'(ex[c].dn));
      chk("rd_en", o_rd, int'(ex[c].rd));
      chk("wr_en", o_wr, int'(ex[c].wr));
      if (ex[c].rd) begin
        chk("rd_addr_a", o_a, ex[c].a);
        chk("rd_addr_b", o_b, ex[c].b);
        chk("tw_idx", o_tw, ex[c].tw);
        chk("mult_prec", o_mp, ex[c].mp);
        chk("add_prec", o_ap, ex[c].ap);
        chk("stage", o_st, ex[c].st);
      end
      if (ex[c].wr) begin
        chk("wr_addr_a", o_wa, ex[c].wa);
        chk("wr_addr_b", o_wb, ex[c].wb);
      end
      if (o_wr != 0) begin
        wcnt[o_wa]++;
        wcnt[o_wb]++;
      end
      if (o_dn != 0 && first_done < 0) first_done = c;
      act_rd[c] = o_rd != 0;
      act_a[c] = o_a;
      act_b[c] = o_b;
      act_tw[c] = o_tw;
      act_mp[c] = o_mp;
      act_ap[c] = o_ap;
    end
    rst = 0;
    start = 0;
  endtask
  initial begin
    int c, len;
    tbl[0] = '{0, 0, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 3, 5, 7, 4, 0, 1};
    tbl[2] = '{2, 6, 10, 14, 4, 1, 0};
    tbl[3] = '{3, 5, 5, 13, 5, 1, 1};
    clear_stim();
    st_v[0] = 1;
    cfg_v[0] = 8'b11_10_01_00;
    st_v[15] = 1;
    cfg_v[15] = 8'h1B;
    run_scn(0, 4, 2, 50, fd);
    cur_c = fd;
    chk("default_done_cycle", fd, 41);
    foreach (tbl[i]) begin
      c = 1 + tbl[i].s * 10 + tbl[i].k;
      cur_c = c;
      chk("tbl_rd_en", int'(act_rd[c]), 1);
      chk("tbl_addr_a", act_a[c], tbl[i].a);
      chk("tbl_addr_b", act_b[c], tbl[i].b);
      chk("tbl_tw", act_tw[c], tbl[i].tw);
      chk("tbl_mult_prec", act_mp[c], tbl[i].mp);
      chk("tbl_add_prec", act_ap[c], tbl[i].ap);
    end
    for (int i = 0; i < 16; i++) chk("wr_cover16", wcnt[i], 4);
    clear_stim();
    st_v[0] = 1;
    cfg_v[0] = 8'b11_10_01_00;
    rdy_v[3] = 0;
    rdy_v[4] = 0;
    rdy_v[5] = 0;
    run_scn(0, 4, 2, 50, fd);
    chk("stall_done_cycle", fd, 44);
    clear_stim();
    st_v[0] = 1;
    cfg_v[0] = 8'h5A;
    rst_v[20] = 1;
    st_v[25] = 1;
    cfg_v[25] = 8'hC3;
    run_scn(0, 4, 2, 75, fd);
    chk("reset_rerun_done_cycle", fd, 66);
    clear_stim();
    st_v[0] = 1;
    cfg_v[0] = 8'h27;
    run_scn(1, 3, 1, 25, fd);
    chk("small_done_cycle", fd, 16);
    for (int i = 0; i < 8; i++) chk("wr_cover8", wcnt[i], 3);
    for (int it = 0; it < 8; it++) begin
      len = 120;
      clear_stim();
      for (int q = 0; q < len; q++) begin
        rdy_v[q] = $urandom_range(3) != 0;
        cfg_v[q] = 8'($urandom);
      end
      st_v[0] = 1;
      for (int q = 0; q < 4; q++) st_v[$urandom_range(len - 1)] = 1;
      if ($urandom_range(2) == 0) rst_v[$urandom_range(60, 10)] = 1;
      if (it % 2 == 0) run_scn(0, 4, 2, len, fd);
      else run_scn(1, 3, 1, len, fd);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
